// File: rtl/imuldiv_int_div_iterative_param_if.sv
// Request/response channel of the iterative divider: val/rdy request carrying
// {fn, a, b}, val/rdy response carrying {remainder, quotient}.
interface imuldiv_int_div_iterative_param_if #(
    parameter int WIDTH = 32
);
    logic               divreq_msg_fn;
    logic [WIDTH-1:0]   divreq_msg_a;
    logic [WIDTH-1:0]   divreq_msg_b;
    logic               divreq_val;
    logic               divreq_rdy;
    logic [2*WIDTH-1:0] divresp_msg_result;
    logic               divresp_val;
    logic               divresp_rdy;

    modport master (
        output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
        input  divreq_rdy, divresp_msg_result, divresp_val
    );

    modport slave (
        input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
        output divreq_rdy, divresp_msg_result, divresp_val
    );
endinterface

// File: rtl/imuldiv_int_div_iterative_param.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned,
// with a divide-by-zero fast path and a response held under backpressure.
module imuldiv_int_div_iterative_param #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    imuldiv_int_div_iterative_param_if.slave div
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int RW = 2 * WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      counter;
    logic [RW-1:0]      rq;
    logic [RW-1:0]      shifted;
    logic [RW-1:0]      diff;
    logic [WIDTH-1:0]   b_mag;
    logic               q_neg;
    logic               r_neg;
    logic [2*WIDTH-1:0] result;
    logic               req_fire;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v) + WIDTH'(1) : v;
    endfunction

    assign a_neg    = div.divreq_msg_fn & div.divreq_msg_a[WIDTH-1];
    assign b_neg    = div.divreq_msg_fn & div.divreq_msg_b[WIDTH-1];
    assign b_zero   = (div.divreq_msg_b == '0);
    assign req_fire = div.divreq_val & div.divreq_rdy;

    // Trial subtraction; bit RW-1 of diff is the borrow (negative result).
    assign shifted  = rq << 1;
    assign diff     = shifted - {1'b0, b_mag, {WIDTH{1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_fire) state_next = b_zero ? DONE : CALC;
            CALC: if (counter == LAST) state_next = SIGN;
            SIGN: state_next = DONE;
            DONE: if (div.divresp_rdy) state_next = IDLE;
        endcase
    end

    // Ready is forced low while reset is held so nothing can fire mid-reset.
    always_comb begin
        div.divreq_rdy  = (state == IDLE) && !reset;
        div.divresp_val = (state == DONE);
    end

    assign div.divresp_msg_result = result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
            rq      <= '0;
            b_mag   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        rq      <= {{(WIDTH + 1){1'b0}}, cond_neg(div.divreq_msg_a, a_neg)};
                        b_mag   <= cond_neg(div.divreq_msg_b, b_neg);
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        counter <= '0;
                        // Divide by zero: all-ones quotient, original dividend as remainder.
                        if (b_zero) begin
                            result <= {div.divreq_msg_a, {WIDTH{1'b1}}};
                        end
                    end
                end
                CALC: begin
                    if (!diff[RW-1]) begin
                        rq <= {diff[RW-1:1], 1'b1};
                    end else begin
                        rq <= shifted;
                    end
                    counter <= counter + CW'(1);
                end
                SIGN: begin
                    result <= {cond_neg(rq[2*WIDTH-1:WIDTH], r_neg),
                               cond_neg(rq[WIDTH-1:0], q_neg)};
                end
                DONE: begin
                end
            endcase
        end
    end
endmodule
